// File: rtl/fs_dither_pkg.sv
// rtl/fs_dither_pkg.sv - shared types and constants for the Floyd-Steinberg dither engine
package fs_dither_pkg;

    // Error numerators: worst case |3e+5e+1e| + |7e| with |e| <= 127 stays below 2^11
    localparam int ERR_W = 13;

    typedef logic signed [ERR_W-1:0] err_t;

    // Diffusion weights over a denominator of 16
    localparam err_t W_R  = err_t'(7);
    localparam err_t W_DL = err_t'(3);
    localparam err_t W_D  = err_t'(5);
    localparam err_t W_DR = err_t'(1);

    localparam int   ERR_SHIFT = 4;
    localparam err_t WHITE     = err_t'(255);

endpackage

// File: rtl/fs_err_linebuf.sv
// rtl/fs_err_linebuf.sv - one-row store of accumulated error numerators
//
// Ports:
//   clk      system clock
//   rd_addr  column to read (combinational read)
//   rd_data  stored numerator for rd_addr
//   wr_en    commit wr_data to wr_addr on the rising edge
//   wr_addr  column to write
//   wr_data  numerator to store
module fs_err_linebuf
    import fs_dither_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output err_t          rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  err_t          wr_data
);

    // No reset: row 0 of every frame ignores the contents
    err_t mem [DEPTH];

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/fs_dither_engine.sv
// rtl/fs_dither_engine.sv - streaming Floyd-Steinberg error-diffusion to 1-bit output
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake, in_pixel is 8-bit unsigned grayscale
//   out_valid/out_ready    output handshake
//   out_bit, out_pixel     dithered pixel (1 = white / 255)
//   out_sof, out_eof       first / last pixel of the frame
module fs_dither_engine
    import fs_dither_pkg::*;
#(
    parameter int IMAGEX    = 64,
    parameter int IMAGEY    = 64,
    parameter int RGB_SIZE  = 8,
    parameter int THRESHOLD = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RGB_SIZE-1:0] in_pixel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_bit,
    output logic [RGB_SIZE-1:0] out_pixel,
    output logic                out_sof,
    output logic                out_eof
);

    localparam int XW = $clog2(IMAGEX);
    localparam int YW = $clog2(IMAGEY);
    localparam logic [XW-1:0] X_LAST = XW'(IMAGEX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGEY - 1);
    localparam err_t THR = err_t'(THRESHOLD);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    err_t carry, p0, p1;

    logic          accept;
    logic          x_first, x_last, y_first;
    err_t          rb_rd, acc, corr, clamped, e;
    logic          pix_bit;
    logic [XW-1:0] wr_addr;
    err_t          wr_data;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    fs_err_linebuf #(.DEPTH(IMAGEX)) u_linebuf (
        .clk     (clk),
        .rd_addr (x),
        .rd_data (rb_rd),
        .wr_en   (accept),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always_comb begin
        x_first = (x == '0);
        x_last  = (x == X_LAST);
        y_first = (y == '0);

        acc  = (y_first ? err_t'(0) : rb_rd) + (x_first ? err_t'(0) : carry);
        corr = err_t'({{(ERR_W-RGB_SIZE){1'b0}}, in_pixel}) + (acc >>> ERR_SHIFT);

        clamped = corr;
        if (corr[ERR_W-1]) begin
            clamped = '0;
        end else if (corr > WHITE) begin
            clamped = WHITE;
        end

        pix_bit = (clamped >= THR);
        e       = clamped - (pix_bit ? WHITE : err_t'(0));

        // The last column's down contribution is held in p0 across the row
        // end and written at the next x==0, where the 3e write is dropped
        // anyway; this keeps the buffer to a single write port.
        if (x_first) begin
            wr_addr = X_LAST;
            wr_data = p0;
        end else begin
            wr_addr = x - XW'(1);
            wr_data = p0 + W_DL * e;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x         <= '0;
            y         <= '0;
            carry     <= '0;
            p0        <= '0;
            p1        <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_pixel <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (accept) begin
            p0        <= p1 + W_D * e;
            p1        <= x_last ? err_t'(0) : W_DR * e;
            carry     <= x_last ? err_t'(0) : W_R * e;
            x         <= x_last ? '0 : x + XW'(1);
            if (x_last) begin
                y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end
            out_valid <= 1'b1;
            out_bit   <= pix_bit;
            out_pixel <= pix_bit ? {RGB_SIZE{1'b1}} : '0;
            out_sof   <= x_first & y_first;
            out_eof   <= x_last & (y == Y_LAST);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/fs_dither_engine.md
# fs_dither_engine

Floyd–Steinberg error-diffusion core. Consumes the 8-bit grayscale stream produced by `pixel_algorithm_unit` in raster order (row 0 first, x ascending), and emits one dithered black/white pixel per input pixel. Output goes to the result memory and the SPI read-back path. Error propagation to the next row uses a single on-chip row buffer of signed accumulated error numerators.

## Interface
- `IMAGEX`, 64: pixels per row (≥2).
- `IMAGEY`, 64: rows per frame.
- `RGB_SIZE`, 8: grayscale pixel width.
- `THRESHOLD`, 128: corrected value ≥ THRESHOLD maps to white.
- `clk` in 1: single system clock; all logic in this domain.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_pixel` valid.
- `in_ready` out 1: engine accepts a pixel when `in_valid & in_ready`.
- `in_pixel` in RGB_SIZE: unsigned grayscale.
- `out_valid` out 1: output pixel valid.
- `out_ready` in 1: downstream accepts when `out_valid & out_ready`.
- `out_bit` out 1: 1 = white, 0 = black.
- `out_pixel` out RGB_SIZE: 255 when `out_bit`, else 0.
- `out_sof` out 1: with `out_valid`, marks pixel (0,0).
- `out_eof` out 1: with `out_valid`, marks pixel (IMAGEX-1, IMAGEY-1).

## Operation
- Counters `x` (0..IMAGEX-1) and `y` (0..IMAGEY-1) advance on each accepted input. x wraps to 0 and increments y. Both wrap to 0 after the last pixel of the frame.
- `in_ready = ~out_valid | out_ready`.
- Error numerators are signed, ERR_W = 13 bits.
- Corrected value: `c = in_pixel + ((rowbuf[x] + carry) >>> 4)`.
  - The shift is arithmetic, so it floors.
  - `rowbuf[x]` reads as 0 when y == 0. The buffer is never explicitly cleared.
  - `carry` is 7·e of the previous pixel. It is forced to 0 at x == 0.
- Clamp c to [0,255]. Then `out_bit = (c ≥ THRESHOLD)` and `e = c − (out_bit ? 255 : 0)`. The range of e is [−127,127].
- Next-row contributions use pending registers `p0` (for x) and `p1` (for x+1). At each accepted pixel:
  - If x > 0: write `rowbuf[x−1] = p0 + 3e`.
  - Then `p0 ← p1 + 5e` and `p1 ← 1e`.
  - At x == 0, the 3e contribution is dropped. p0/p1 start at 0 for the row.
  - At x == IMAGEX−1, additionally write `rowbuf[IMAGEX−1] = p0_new`. The 1e contribution and carry are dropped, and p0/p1 are cleared.
  - Every rowbuf address is read (for row y) before it is rewritten (for row y+1).
- During row IMAGEY−1, rowbuf writes may occur but are irrelevant, because the next frame gates row 0.
- Reset, including mid-frame: x, y, carry, p0, p1 and all outputs go to 0. `in_ready` = 1 after reset. Rowbuf contents are untouched and harmless.

## Timing
- Output register stage: a pixel accepted at edge N gives `out_valid` = 1 after edge N.
- Throughput is 1 pixel/cycle while `out_ready` stays high.
- Stall: while `out_valid & ~out_ready`, the outputs hold stable, `in_ready` = 0, and no counter or buffer state changes.
- Simultaneous output accept and input accept in the same cycle: the output register reloads with the new pixel, with no bubble.
- Rowbuf read is combinational on address x. The write commits at the accepting edge.
- Reset values: `out_valid`, `out_bit`, `out_pixel`, `out_sof`, `out_eof` all 0; `in_ready` 1.

## Structure
- Package `fs_dither_pkg` holds:
  - `ERR_W`;
  - `typedef logic signed [ERR_W-1:0] err_t`;
  - weight constants W_R = 7, W_DL = 3, W_D = 5, W_DR = 1;
  - the shift constant 4;
  - `WHITE` = 255.
- Sub-module `fs_err_linebuf`: IMAGEX × err_t storage with async read port (x) and sync write port.
- Top level holds the counters, the error datapath, and the output register.

## Test plan
- Reset: assert `rst` low, release → `out_valid` = 0, `in_ready` = 1; first accepted pixel produces `out_sof` = 1.
- Flat frames: all-0 input → 4096 outputs, all `out_bit` 0. All-255 input → all 1, `out_eof` only on the 4096th output.
- Uniform 128, row 0:
  - (0,0): c = 128 → 1, e = −127.
  - (1,0): c = 128 + floor(−889/16) = 72 → 0.
  - Whole frame: white count within ±64 of 2048.
- Row edge, no wrap carry: (63,0) = 100, all other row-0 pixels 0, (0,1) = 127 → (0,1) output 0. A wrongly carried error would produce 1.
- Backpressure: drop `out_ready` for 5 cycles mid-row on random input → `in_ready` low for those cycles, outputs held. Full output sequence equals the stall-free golden model.
- Mid-frame reset: after 10 rows of random input, reset, then a frame of all 127 → (0,0) output 0, and the whole frame matches the output from a fresh reset.
